gpr_wb_arb: RTL and testbench
=============================

Name: gpr_wb_arb

Overview:
Arbitrates the single GPR write port between three writeback sources and keeps a scoreboard of registers with outstanding long-latency writes.
- Source 0 is the in-order pipeline writeback. It is never back-pressured.
- Source 1 is the multi-cycle mul/div unit.
- Source 2 is the load unit.

The block drives we/waddr/wdata of gpr and gives decode busy flags for its two read addresses, so decode can stall on RAW hazards against pending writes.

Parameters:
GPR_AW, 5, GPR address width
GPR_DW, 32, GPR data width
GPR_N, 32, number of registers (scoreboard bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (`RstEnable = 1'b0`)
pl_we  in  1  pipeline writeback valid (no ready)
pl_waddr  in  GPR_AW  pipeline writeback address
pl_wdata  in  GPR_DW  pipeline writeback data
md_valid  in  1  mul/div result valid
md_ready  out  1  mul/div result accepted this cycle
md_waddr  in  GPR_AW  mul/div destination
md_wdata  in  GPR_DW  mul/div result
ld_valid  in  1  load result valid
ld_ready  out  1  load result accepted this cycle
ld_waddr  in  GPR_AW  load destination
ld_wdata  in  GPR_DW  load data
sb_set  in  1  decode issues a long-latency op (md or ld)
sb_addr  in  GPR_AW  its destination register
re1_addr  in  GPR_AW  decode read address 1
re2_addr  in  GPR_AW  decode read address 2
busy1  out  1  re1_addr has a pending write
busy2  out  1  re2_addr has a pending write
gpr_we  out  1  to gpr we
gpr_waddr  out  GPR_AW  to gpr waddr
gpr_wdata  out  GPR_DW  to gpr wdata
sb_err  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, asynchronous):
  - gpr_we=0, gpr_waddr=0, gpr_wdata=0.
  - Scoreboard cleared, rr_ptr=MD, sb_err=0.
  - md_ready=ld_ready=0 while in reset.
- Write port is registered, one cycle latency: a source granted in cycle N appears on gpr_we/waddr/wdata in cycle N+1 for exactly one cycle. With no grant in N, gpr_we=0 in N+1 and waddr/wdata hold their previous values.
- Priority: pl_we=1 always wins.
  - md_ready=ld_ready=0 in any cycle with pl_we=1.
  - Otherwise, when both md_valid and ld_valid are 1, rr_ptr selects the winner.
  - rr_ptr toggles to the other unit only after a grant to the unit it points at.
  - If only one of md_valid/ld_valid is 1, that one is granted.
- ready is combinational from the valids and pl_we; a transfer is valid & ready. Sources hold valid and data stable until accepted.
- Scoreboard update, GPR_N bits, bit 0 hardwired 0:
  - Set bit sb_addr on sb_set when sb_addr != 0.
  - Clear bit gpr_waddr when gpr_we=1 and that write came from md or ld (tracked by a registered source tag). Pipeline writes never clear.
  - Set and clear of the same bit in the same cycle: set wins.
- Busy outputs:
  - busyK = sb[reK_addr] & ~(gpr_we & tag_is_mdld & gpr_waddr==reK_addr).
  - This relies on gpr's same-cycle write-to-read bypass.
  - reK_addr=0 gives busyK=0.
- sb_err is set, and holds until reset, when:
  - sb_set targets an already-set bit (and is not being cleared that cycle); or
  - an md/ld write is accepted to a nonzero address whose bit is 0.
- Address 0 writes: accepted and forwarded. gpr ignores them and the scoreboard is unaffected.
- Reset mid-transfer: a pending registered write is dropped (gpr_we=0) and all pending busy bits are lost. The core flushes on reset.

Decomposition:
- Shared definitions package/include: GPR_AW, GPR_DW, GPR_N (already global), source tag encoding SRC_PL=2'd0 / SRC_MD=2'd1 / SRC_LD=2'd2, and `RstEnable`.
- One natural sub-module: gpr_scoreboard (set/clear/lookup with bypass, sb_err). The arbiter and output register stay in the top module.

Test Plan:
1. Reset release, idle: gpr_we=0, busy1=busy2=0, sb_err=0; all outputs 0 during rst=0.
2. pl_we=1 (waddr=5, data=0x11) and md_valid=1 (waddr=6) in cycle N:
   - md_ready=0 in N; cycle N+1 has gpr_we=1, waddr=5, wdata=0x11.
   - With pl_we=0 in N+1, md_ready=1 in N+1; cycle N+2 has waddr=6.
3. md_valid and ld_valid both held high for 4 cycles with pl_we=0: grants alternate MD, LD, MD, LD (rr_ptr starts at MD).
4. sb_set addr=7, re1_addr=7:
   - busy1=1 the next cycle.
   - ld writes 7 (0xABCD): busy1=0 in the same cycle gpr_we=1, waddr=7; busy1 stays 0 afterwards.
5. Write-clear and sb_set of reg 9 in the same cycle: bit 9 stays set and busy persists; sb_err=0.
6. sb_set addr=3 twice with no writeback in between: sb_err=1 and remains 1 until rst=0. sb_set addr=0: no busy, no error.

Source files
------------

// File: rtl/gpr_wb_arb_pkg.sv
// Shared widths, reset polarity and writeback source tags for the GPR
// writeback arbiter and its scoreboard.
package gpr_wb_arb_pkg;

  localparam int   GPR_AW     = 5;
  localparam int   GPR_DW     = 32;
  localparam int   GPR_N      = 32;
  localparam logic RST_ENABLE = 1'b0;

  typedef enum logic [1:0] {
    SRC_PL = 2'd0,
    SRC_MD = 2'd1,
    SRC_LD = 2'd2
  } src_e;

  typedef enum logic {
    RR_MD = 1'b0,
    RR_LD = 1'b1
  } rr_e;

  // Only mul/div and load writes retire a scoreboard entry.
  function automatic logic is_long_src(input src_e src);
    return src != SRC_PL;
  endfunction

endpackage

// File: rtl/gpr_wb_arb_if.sv
// Bundle of writeback sources, decode scoreboard hooks and the GPR write port.
interface gpr_wb_arb_if;
  import gpr_wb_arb_pkg::*;

  logic              pl_we;
  logic [GPR_AW-1:0] pl_waddr;
  logic [GPR_DW-1:0] pl_wdata;
  logic              md_valid;
  logic              md_ready;
  logic [GPR_AW-1:0] md_waddr;
  logic [GPR_DW-1:0] md_wdata;
  logic              ld_valid;
  logic              ld_ready;
  logic [GPR_AW-1:0] ld_waddr;
  logic [GPR_DW-1:0] ld_wdata;
  logic              sb_set;
  logic [GPR_AW-1:0] sb_addr;
  logic [GPR_AW-1:0] re1_addr;
  logic [GPR_AW-1:0] re2_addr;
  logic              busy1;
  logic              busy2;
  logic              gpr_we;
  logic [GPR_AW-1:0] gpr_waddr;
  logic [GPR_DW-1:0] gpr_wdata;
  logic              sb_err;

  modport slave (
    input  pl_we, pl_waddr, pl_wdata,
    input  md_valid, md_waddr, md_wdata,
    input  ld_valid, ld_waddr, ld_wdata,
    input  sb_set, sb_addr, re1_addr, re2_addr,
    output md_ready, ld_ready, busy1, busy2,
    output gpr_we, gpr_waddr, gpr_wdata, sb_err
  );

  modport master (
    output pl_we, pl_waddr, pl_wdata,
    output md_valid, md_waddr, md_wdata,
    output ld_valid, ld_waddr, ld_wdata,
    output sb_set, sb_addr, re1_addr, re2_addr,
    input  md_ready, ld_ready, busy1, busy2,
    input  gpr_we, gpr_waddr, gpr_wdata, sb_err
  );

endinterface

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one bit per GPR, set at issue, cleared when the
// long-latency result reaches the GPR; busy lookups see the clearing write.
module gpr_scoreboard
  import gpr_wb_arb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_set,
  input  logic [GPR_AW-1:0] i_set_addr,
  input  logic              i_clr,
  input  logic [GPR_AW-1:0] i_clr_addr,
  input  logic              i_acc,
  input  logic [GPR_AW-1:0] i_acc_addr,
  input  logic [GPR_AW-1:0] i_re1_addr,
  input  logic [GPR_AW-1:0] i_re2_addr,
  output logic              o_busy1,
  output logic              o_busy2,
  output logic              o_err
);

  logic [GPR_N-1:0] r_sb;
  logic             r_err;
  logic [GPR_N-1:0] w_set_mask;
  logic [GPR_N-1:0] w_clr_mask;
  logic [GPR_N-1:0] w_sb_nxt;
  logic             w_err_set;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set) w_set_mask[i_set_addr] = 1'b1;
    if (i_clr) w_clr_mask[i_clr_addr] = 1'b1;
    // Set is applied after clear so an issue and a retire on one register keep it pending.
    w_sb_nxt    = (r_sb & ~w_clr_mask) | w_set_mask;
    w_sb_nxt[0] = 1'b0;
    w_err_set   = (i_set && (i_set_addr != '0) && r_sb[i_set_addr] && !w_clr_mask[i_set_addr])
               || (i_acc && (i_acc_addr != '0) && !r_sb[i_acc_addr]);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (i_rst == RST_ENABLE) begin
      r_sb  <= '0;
      r_err <= 1'b0;
    end else begin
      r_sb  <= w_sb_nxt;
      r_err <= r_err | w_err_set;
    end
  end

  assign o_busy1 = r_sb[i_re1_addr] & ~w_clr_mask[i_re1_addr];
  assign o_busy2 = r_sb[i_re2_addr] & ~w_clr_mask[i_re2_addr];
  assign o_err   = r_err;

endmodule

// File: rtl/gpr_wb_arb.sv
// GPR write-port arbiter: pipeline writeback has absolute priority, mul/div
// and load share the remaining slots round-robin; the port is registered.
module gpr_wb_arb
  import gpr_wb_arb_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  gpr_wb_arb_if.slave bus
);

  rr_e               r_rr_ptr;
  rr_e               w_rr_nxt;
  logic              r_we;
  logic [GPR_AW-1:0] r_waddr;
  logic [GPR_DW-1:0] r_wdata;
  src_e              r_tag;

  logic              w_in_rst;
  logic              w_md_ready;
  logic              w_ld_ready;
  logic              w_md_fire;
  logic              w_ld_fire;
  logic              w_grant;
  src_e              w_src;
  logic [GPR_AW-1:0] w_waddr;
  logic [GPR_DW-1:0] w_wdata;

  assign w_in_rst = (i_rst == RST_ENABLE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (i_rst == RST_ENABLE) r_rr_ptr <= RR_MD;
    else                     r_rr_ptr <= w_rr_nxt;
  end

  always_comb begin
    w_md_ready = 1'b0;
    w_ld_ready = 1'b0;
    w_rr_nxt   = r_rr_ptr;
    if (!w_in_rst && !bus.pl_we) begin
      if (bus.md_valid && bus.ld_valid) begin
        w_md_ready = (r_rr_ptr == RR_MD);
        w_ld_ready = (r_rr_ptr == RR_LD);
      end else begin
        w_md_ready = bus.md_valid;
        w_ld_ready = bus.ld_valid;
      end
    end
    w_md_fire = bus.md_valid & w_md_ready;
    w_ld_fire = bus.ld_valid & w_ld_ready;
    // The pointer only moves once the unit it favours has been served.
    if (w_md_fire && r_rr_ptr == RR_MD)      w_rr_nxt = RR_LD;
    else if (w_ld_fire && r_rr_ptr == RR_LD) w_rr_nxt = RR_MD;
  end

  always_comb begin
    w_src   = SRC_PL;
    w_waddr = bus.pl_waddr;
    w_wdata = bus.pl_wdata;
    if (w_md_fire) begin
      w_src   = SRC_MD;
      w_waddr = bus.md_waddr;
      w_wdata = bus.md_wdata;
    end else if (w_ld_fire) begin
      w_src   = SRC_LD;
      w_waddr = bus.ld_waddr;
      w_wdata = bus.ld_wdata;
    end
    w_grant = bus.pl_we | w_md_fire | w_ld_fire;
  end

  // Address/data hold between writes; only the strobe drops.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (i_rst == RST_ENABLE) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_tag   <= SRC_PL;
    end else begin
      r_we <= w_grant;
      if (w_grant) begin
        r_waddr <= w_waddr;
        r_wdata <= w_wdata;
        r_tag   <= w_src;
      end
    end
  end

  gpr_scoreboard u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_set      (bus.sb_set),
    .i_set_addr (bus.sb_addr),
    .i_clr      (r_we & is_long_src(r_tag)),
    .i_clr_addr (r_waddr),
    .i_acc      (w_md_fire | w_ld_fire),
    .i_acc_addr (w_md_fire ? bus.md_waddr : bus.ld_waddr),
    .i_re1_addr (bus.re1_addr),
    .i_re2_addr (bus.re2_addr),
    .o_busy1    (bus.busy1),
    .o_busy2    (bus.busy2),
    .o_err      (bus.sb_err)
  );

  assign bus.md_ready  = w_md_ready;
  assign bus.ld_ready  = w_ld_ready;
  assign bus.gpr_we    = r_we;
  assign bus.gpr_waddr = r_waddr;
  assign bus.gpr_wdata = r_wdata;

endmodule

// File: tb/tb_gpr_wb_arb.sv
// Bench for gpr_wb_arb: directed scenarios plus a randomized legal-traffic
// run, every cycle compared against a behavioural model of the arbiter.
module tb_gpr_wb_arb;
  import gpr_wb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gpr_wb_arb_if bus ();

  gpr_wb_arb dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit [GPR_N-1:0]    m_sb;
  bit                m_rr_ld;
  bit                m_we;
  bit                m_long;
  bit                m_err;
  logic [GPR_AW-1:0] m_waddr;
  logic [GPR_DW-1:0] m_wdata;
  bit                g_md_fire;
  bit                g_ld_fire;

  // Random-traffic bookkeeping
  bit pend [GPR_N];
  int md_q [$];
  int ld_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.pl_we    = 1'b0;  bus.pl_waddr = '0; bus.pl_wdata = '0;
    bus.md_valid = 1'b0;  bus.md_waddr = '0; bus.md_wdata = '0;
    bus.ld_valid = 1'b0;  bus.ld_waddr = '0; bus.ld_wdata = '0;
    bus.sb_set   = 1'b0;  bus.sb_addr  = '0;
    bus.re1_addr = '0;    bus.re2_addr = '0;
  endtask

  function automatic bit model_busy(input logic [GPR_AW-1:0] a);
    return m_sb[a] && !(m_we && m_long && m_waddr == a);
  endfunction

  // Compares every output with the model for the current cycle, then advances
  // the model across the coming rising edge and waits for the next falling edge.
  task automatic tick();
    bit e_md, e_ld, md_fire, ld_fire;
    e_md = 1'b0;
    e_ld = 1'b0;
    if (!bus.pl_we) begin
      if (bus.md_valid && bus.ld_valid) begin
        e_md = !m_rr_ld;
        e_ld = m_rr_ld;
      end else begin
        e_md = bus.md_valid;
        e_ld = bus.ld_valid;
      end
    end
    check("md_ready",  32'(bus.md_ready),  32'(e_md));
    check("ld_ready",  32'(bus.ld_ready),  32'(e_ld));
    check("gpr_we",    32'(bus.gpr_we),    32'(m_we));
    check("gpr_waddr", 32'(bus.gpr_waddr), 32'(m_waddr));
    check("gpr_wdata", bus.gpr_wdata,      m_wdata);
    check("busy1",     32'(bus.busy1),     32'(model_busy(bus.re1_addr)));
    check("busy2",     32'(bus.busy2),     32'(model_busy(bus.re2_addr)));
    check("sb_err",    32'(bus.sb_err),    32'(m_err));

    md_fire = bus.md_valid && e_md;
    ld_fire = bus.ld_valid && e_ld;
    if (bus.sb_set && bus.sb_addr != 0 && m_sb[bus.sb_addr] && model_busy(bus.sb_addr)) m_err = 1'b1;
    if (md_fire && bus.md_waddr != 0 && !m_sb[bus.md_waddr]) m_err = 1'b1;
    if (ld_fire && bus.ld_waddr != 0 && !m_sb[bus.ld_waddr]) m_err = 1'b1;
    if (m_we && m_long) m_sb[m_waddr] = 1'b0;
    if (bus.sb_set && bus.sb_addr != 0) m_sb[bus.sb_addr] = 1'b1;
    if (md_fire && !m_rr_ld)     m_rr_ld = 1'b1;
    else if (ld_fire && m_rr_ld) m_rr_ld = 1'b0;
    m_we = bus.pl_we || md_fire || ld_fire;
    if (bus.pl_we) begin
      m_waddr = bus.pl_waddr; m_wdata = bus.pl_wdata; m_long = 1'b0;
    end else if (md_fire) begin
      m_waddr = bus.md_waddr; m_wdata = bus.md_wdata; m_long = 1'b1;
    end else if (ld_fire) begin
      m_waddr = bus.ld_waddr; m_wdata = bus.ld_wdata; m_long = 1'b1;
    end
    g_md_fire = md_fire;
    g_ld_fire = ld_fire;
    @(negedge clk);
  endtask

  // Asserts reset with busy-looking inputs, checks every output is quiet, releases.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    bus.pl_we = 1'b1; bus.md_valid = 1'b1; bus.ld_valid = 1'b1;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd4; bus.re1_addr = 5'd4; bus.re2_addr = 5'd4;
    #1;
    check({tag, "_we"},    32'(bus.gpr_we),    0);
    check({tag, "_waddr"}, 32'(bus.gpr_waddr), 0);
    check({tag, "_wdata"}, bus.gpr_wdata,      0);
    check({tag, "_mdrdy"}, 32'(bus.md_ready),  0);
    check({tag, "_ldrdy"}, 32'(bus.ld_ready),  0);
    check({tag, "_busy"},  32'(bus.busy1 | bus.busy2), 0);
    check({tag, "_err"},   32'(bus.sb_err),    0);
    @(negedge clk);
    @(negedge clk);
    idle();
    m_sb = '0; m_rr_ld = 1'b0; m_we = 1'b0; m_long = 1'b0; m_err = 1'b0;
    m_waddr = '0; m_wdata = '0; g_md_fire = 1'b0; g_ld_fire = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset("rst0");

    // Idle after reset
    for (int i = 0; i < 2; i++) begin
      #1;
      check("idle_we",   32'(bus.gpr_we), 0);
      check("idle_busy", 32'(bus.busy1 | bus.busy2), 0);
      check("idle_err",  32'(bus.sb_err), 0);
      tick();
    end

    // Pipeline priority over mul/div
    bus.sb_set = 1'b1; bus.sb_addr = 5'd6;
    #1; tick();
    bus.sb_set = 1'b0;
    bus.pl_we = 1'b1; bus.pl_waddr = 5'd5; bus.pl_wdata = 32'h11;
    bus.md_valid = 1'b1; bus.md_waddr = 5'd6; bus.md_wdata = 32'h66;
    #1;
    check("prio_md_blocked", 32'(bus.md_ready), 0);
    tick();
    bus.pl_we = 1'b0;
    #1;
    check("prio_pl_we",    32'(bus.gpr_we),    1);
    check("prio_pl_waddr", 32'(bus.gpr_waddr), 5);
    check("prio_pl_wdata", bus.gpr_wdata,      32'h11);
    check("prio_md_ready", 32'(bus.md_ready),  1);
    tick();
    bus.md_valid = 1'b0;
    #1;
    check("prio_md_waddr", 32'(bus.gpr_waddr), 6);
    check("prio_md_wdata", bus.gpr_wdata,      32'h66);
    tick();
    #1;
    check("hold_we",    32'(bus.gpr_we),    0);
    check("hold_waddr", 32'(bus.gpr_waddr), 6);
    tick();

    // Round-robin alternation from a fresh pointer
    do_reset("rst1");
    for (int i = 0; i < 5; i++) begin
      bus.sb_set = 1'b1; bus.sb_addr = GPR_AW'(10 + i);
      #1; tick();
    end
    bus.sb_set = 1'b0;
    bus.md_valid = 1'b1; bus.md_waddr = 5'd10; bus.md_wdata = $urandom;
    bus.ld_valid = 1'b1; bus.ld_waddr = 5'd11; bus.ld_wdata = $urandom;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_md_ready", 32'(bus.md_ready), 32'(i % 2 == 0));
      check("rr_ld_ready", 32'(bus.ld_ready), 32'(i % 2 == 1));
      if (i > 0) check("rr_waddr", 32'(bus.gpr_waddr), 32'(10 + i - 1));
      tick();
      case (i)
        0: begin bus.md_waddr = 5'd12; bus.md_wdata = $urandom; end
        1: begin bus.ld_waddr = 5'd13; bus.ld_wdata = $urandom; end
        2: begin bus.md_waddr = 5'd14; bus.md_wdata = $urandom; end
        default: bus.ld_valid = 1'b0;
      endcase
    end
    #1;
    check("rr_last_waddr", 32'(bus.gpr_waddr), 13);
    tick();
    bus.md_valid = 1'b0;
    #1; tick();
    #1; tick();

    // Busy set and cleared through the write bypass
    bus.sb_set = 1'b1; bus.sb_addr = 5'd7; bus.re1_addr = 5'd7;
    #1; tick();
    bus.sb_set = 1'b0;
    #1;
    check("byp_busy_set", 32'(bus.busy1), 1);
    bus.ld_valid = 1'b1; bus.ld_waddr = 5'd7; bus.ld_wdata = 32'hABCD;
    #1; tick();
    bus.ld_valid = 1'b0;
    #1;
    check("byp_we",    32'(bus.gpr_we),    1);
    check("byp_waddr", 32'(bus.gpr_waddr), 7);
    check("byp_wdata", bus.gpr_wdata,      32'hABCD);
    check("byp_busy",  32'(bus.busy1),     0);
    tick();
    #1;
    check("byp_busy_after", 32'(bus.busy1), 0);
    tick();

    // Set wins over clear on the same register
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9; bus.re2_addr = 5'd9;
    #1; tick();
    bus.sb_set = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_waddr = 5'd9; bus.ld_wdata = $urandom;
    #1; tick();
    bus.ld_valid = 1'b0;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    #1;
    check("sw_clr_waddr", 32'(bus.gpr_waddr), 9);
    tick();
    bus.sb_set = 1'b0;
    #1;
    check("sw_busy", 32'(bus.busy2),  1);
    check("sw_err",  32'(bus.sb_err), 0);
    tick();
    bus.md_valid = 1'b1; bus.md_waddr = 5'd9; bus.md_wdata = $urandom;
    #1; tick();
    bus.md_valid = 1'b0;
    #1;
    check("sw_busy_byp", 32'(bus.busy2), 0);
    tick();
    #1;
    check("sw_busy_clr", 32'(bus.busy2), 0);
    tick();

    // Register 0 never busy; double issue is a sticky error
    bus.sb_set = 1'b1; bus.sb_addr = 5'd0; bus.re1_addr = 5'd0;
    #1; tick();
    bus.sb_set = 1'b0;
    #1;
    check("r0_busy", 32'(bus.busy1),  0);
    check("r0_err",  32'(bus.sb_err), 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.sb_set = 1'b1; bus.sb_addr = 5'd3;
      #1; tick();
    end
    bus.sb_set = 1'b0;
    #1;
    check("dbl_err", 32'(bus.sb_err), 1);
    tick();
    for (int i = 0; i < 3; i++) begin #1; tick(); end
    #1;
    check("dbl_err_sticky", 32'(bus.sb_err), 1);
    @(negedge clk);
    do_reset("rst2");

    // Randomized legal traffic: decode only issues free registers, results
    // arrive after issue, sources hold until accepted.
    md_q.delete();
    ld_q.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (g_md_fire) begin pend[md_q[0]] = 1'b0; void'(md_q.pop_front()); bus.md_valid = 1'b0; end
      if (g_ld_fire) begin pend[ld_q[0]] = 1'b0; void'(ld_q.pop_front()); bus.ld_valid = 1'b0; end
      if (!bus.md_valid && md_q.size() > 0 && $urandom_range(1, 0) == 1) begin
        bus.md_valid = 1'b1; bus.md_waddr = GPR_AW'(md_q[0]); bus.md_wdata = $urandom;
      end
      if (!bus.ld_valid && ld_q.size() > 0 && $urandom_range(1, 0) == 1) begin
        bus.ld_valid = 1'b1; bus.ld_waddr = GPR_AW'(ld_q[0]); bus.ld_wdata = $urandom;
      end
      bus.pl_we    = ($urandom_range(2, 0) == 0);
      bus.pl_waddr = GPR_AW'($urandom_range(GPR_N - 1, 0));
      bus.pl_wdata = $urandom;
      bus.sb_set   = 1'b0;
      if ($urandom_range(2, 0) == 0) begin
        int a;
        a = $urandom_range(GPR_N - 1, 0);
        if (a == 0 || (!m_sb[a] && !pend[a])) begin
          bus.sb_set = 1'b1;
          bus.sb_addr = GPR_AW'(a);
          if (a != 0) pend[a] = 1'b1;
          if ($urandom_range(1, 0) == 1) md_q.push_back(a);
          else                           ld_q.push_back(a);
        end
      end
      bus.re1_addr = (md_q.size() > 0 && $urandom_range(1, 0) == 1) ? GPR_AW'(md_q[0])
                                                                    : GPR_AW'($urandom_range(GPR_N - 1, 0));
      bus.re2_addr = (ld_q.size() > 0 && $urandom_range(1, 0) == 1) ? GPR_AW'(ld_q[0])
                                                                    : GPR_AW'($urandom_range(GPR_N - 1, 0));
      #1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
